regfile_arbiter: RTL
====================

# regfile_arbiter

Round-robin arbiter and sequencer for a shared single-port register file built from synchronous-reset register storage. Up to NREQ requesters issue read/write transactions over a valid/ready handshake; the block grants at most one per cycle, performs the access on the internal DEPTH x WIDTH array, and returns read data one cycle later. It sits between control-path masters (CSR decoders, DMA descriptors, debug ports) and shared configuration/state registers.

## Interface
- NREQ, 2: number of requesters (2..8).
- WIDTH, 32: data width in bits.
- DEPTH, 16: number of entries (2..256, need not be a power of two).
- AW, $clog2(DEPTH): address width (derived, not overridden).
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester transaction valid.
- req_ready  output  NREQ  one-hot grant; the transaction is accepted when valid & ready.
- req_we  input  NREQ  1 = write, 0 = read.
- req_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- req_lock  input  NREQ  hold-grant request; present only when REGFILE_ARB_LOCK_EN is defined.
- rsp_valid  output  NREQ  one-hot read-response strobe.
- rsp_rdata  output  WIDTH  read data, shared; valid only while a rsp_valid bit is high.

## Operation
- Grant is combinational from req_valid and the registered round-robin pointer `ptr`. The winner is the first i with req_valid[i] set, scanning ptr, ptr+1, … modulo NREQ. req_ready is zero when no request is valid.
- req_ready never asserts for a requester whose req_valid is low. Requesters must hold req_we, req_addr and req_wdata stable while valid and not ready.
- On acceptance, `ptr` becomes (winner+1) mod NREQ. With no acceptance, `ptr` holds.
- Write accept: mem[addr] <= wdata at that clock edge. No response is generated.
- Read accept: on the next cycle, rsp_valid[winner] = 1 and rsp_rdata = mem[addr] as it was before the edge. A write accepted in cycle N is visible to a read accepted in cycle N+1.
- addr >= DEPTH: writes are dropped. Reads complete normally with rsp_rdata = 0.
- Reset: all mem entries become 0, ptr becomes 0, and rsp_valid becomes 0. rsp_rdata resets to 0 and holds 0 whenever no response is pending.
- Reset mid-operation: a read accepted in the cycle where rst is high is discarded and produces no response. req_ready is forced to 0 while rst is high.

## Timing
- Grant: 0-cycle latency (same cycle as req_valid). Throughput is 1 transaction per cycle.
- Read latency is exactly 1 cycle from acceptance to rsp_valid. rsp_valid is high for exactly one cycle, with no backpressure.
- A write takes effect at the accepting edge.
- Back-to-back accepts from different requesters in consecutive cycles are allowed.
- Fairness: any continuously valid requester is granted within NREQ cycles, or within NREQ grants once locks are released when REGFILE_ARB_LOCK_EN is defined.

## Configuration
- REGFILE_ARB_LOCK_EN defined:
  - The req_lock port exists.
  - If the accepted winner has req_lock set, the block enters the LOCKED state with owner = winner, and ptr is not advanced.
  - In LOCKED, only the owner is eligible for grant; other requesters see req_ready = 0.
  - LOCKED returns to IDLE when the owner has an accepted transaction with req_lock = 0, or when the owner drops req_valid. On leaving LOCKED, ptr = (owner+1) mod NREQ.
  - rst forces IDLE.
- REGFILE_ARB_LOCK_EN undefined:
  - The port is absent and there is no lock state.
  - Arbitration is pure round-robin.

## Test plan
- Reset and read: assert rst 2 cycles. Requester 0 reads addr 5 -> rsp_valid = 0b01 one cycle later, rsp_rdata = 0.
- Write then read: req0 writes 0xDEADBEEF to addr 3 in cycle N, req1 reads addr 3 in cycle N+1 -> rsp_valid[1] in N+2 with 0xDEADBEEF.
- Round-robin: NREQ = 4, all valid continuously -> grant order 0,1,2,3,0,… with one accept per cycle.
- Out-of-range: DEPTH = 10, write 0x1234 to addr 12, then read addr 12 and addr 2 -> both return 0, and no entry is modified.
- Reset mid-read: read accepted in the same cycle rst is high -> no rsp_valid afterwards, ptr = 0, mem all 0.
- Lock (REGFILE_ARB_LOCK_EN): req1 accepted with lock while req0 and req2 are valid -> only req1 is granted for 3 more cycles. Then req1 is accepted with lock = 0 -> next grant goes to req2.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Request/response bundle between requesters and regfile_arbiter.
// req_lock exists only when REGFILE_ARB_LOCK_EN is defined.
interface regfile_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
`ifdef REGFILE_ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;
`endif
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;

`ifdef REGFILE_ARB_LOCK_EN
  modport master (output req_valid, req_we, req_addr, req_wdata, req_lock,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_lock,
                  output req_ready, rsp_valid, rsp_rdata);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter in front of a reset-cleared DEPTH x WIDTH register file.
// Grant locking is compiled in when REGFILE_ARB_LOCK_EN is defined.
module regfile_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  regfile_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_next;
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_sum;
  logic             w_any;
  logic             w_accept;
  logic             w_sel_we;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_in_range;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_rdata;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    next_idx = (32'(idx) == NREQ - 1) ? '0 : idx + PW'(1);
  endfunction

  // Scan ptr, ptr+1, ... modulo NREQ; first eligible requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_any && w_elig[w_sum[PW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_sum[PW-1:0];
      end
    end
  end

  assign w_accept = w_any && !rst;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign w_grant[gi] = w_accept && (w_win == PW'(gi));
  end

  assign w_sel_we    = bus.req_we[w_win];
  assign w_sel_addr  = bus.req_addr[w_win*AW +: AW];
  assign w_sel_wdata = bus.req_wdata[w_win*WIDTH +: WIDTH];
  assign w_in_range  = (32'(w_sel_addr) < 32'(DEPTH));

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] w_owner_next;

  assign w_elig = (r_state == ST_LOCKED) ? (bus.req_valid & (NREQ'(1) << r_owner))
                                         : bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
    end
  end

  // ptr freezes while locked and resumes after the owner on release.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.req_lock[w_win]) begin
            w_state_next = ST_LOCKED;
            w_owner_next = w_win;
          end else begin
            w_ptr_next = next_idx(w_win);
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.req_valid[r_owner] || (w_accept && !bus.req_lock[r_owner])) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = next_idx(r_owner);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end
`else
  assign w_elig     = bus.req_valid;
  assign w_ptr_next = w_accept ? next_idx(w_win) : r_ptr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_accept && w_sel_we && w_in_range) begin
      r_mem[w_sel_addr] <= w_sel_wdata;
    end
  end

  // Read data is captured from pre-edge contents; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_accept && !w_sel_we) begin
        r_rsp_valid <= w_grant;
        r_rsp_rdata <= w_in_range ? r_mem[w_sel_addr] : '0;
      end else begin
        r_rsp_valid <= '0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule
